// File: rtl/cla_seq_pkg.sv
// Shared definitions for the sequenced carry-lookahead adder:
// FSM state encoding and default datapath geometry.
package cla_seq_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Default operand width and bits added per cycle
    localparam int CLA_SEQ_WIDTH = 32;
    localparam int CLA_SEQ_SLICE = 4;

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder slice.
// Exports the carry into its top bit so the caller can derive signed overflow.
module cla_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_top
);

    logic [SLICE-1:0] gen;
    logic [SLICE-1:0] prop;
    logic [SLICE:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is a flat sum-of-products of generates, propagates and cin,
    // so no carry waits on a lower carry.
    for (genvar gi = 0; gi <= SLICE; gi++) begin : g_carry
        logic c_bit;

        // Lookahead term for carry into bit gi
        always_comb begin
            logic run_p;
            c_bit = 1'b0;
            run_p = 1'b1;
            for (int j = gi - 1; j >= 0; j--) begin
                c_bit = c_bit | (gen[j] & run_p);
                run_p = run_p & prop[j];
            end
            c_bit = c_bit | (cin & run_p);
        end

        assign carry[gi] = c_bit;
    end

    // Per-bit sum cells
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_sum
        assign sum[gi] = prop[gi] ^ carry[gi];
    end

    assign cout  = carry[SLICE];
    assign c_top = carry[SLICE-1];

endmodule

// File: rtl/cla_add_sequencer.sv
// Multi-cycle adder controller: latches two WIDTH-bit operands, then walks one
// shared SLICE-bit CLA slice across them LSB slice first, one slice per clock.
// Optional subtract support is compiled in when CLA_SEQ_SUB_EN is defined.
module cla_add_sequencer
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = CLA_SEQ_WIDTH,
    parameter int SLICE = CLA_SEQ_SLICE
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub_i,
`endif
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int IW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [IW-1:0]    base_idx;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_ctop;

    // Bit offset of the slice being processed this cycle
    assign base_idx = IW'(cnt_reg) * IW'(SLICE);

    cla_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a     (a_reg[base_idx +: SLICE]),
        .b     (b_reg[base_idx +: SLICE]),
        .cin   (carry_reg),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_top (slice_ctop)
    );

    // Control FSM and all datapath registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        a_reg   <= a_i;
`ifdef CLA_SEQ_SUB_EN
                        // A - B = A + ~B + 1; cout=1 then means no borrow
                        b_reg     <= sub_i ? ~b_i : b_i;
                        carry_reg <= sub_i | cin_i;
`else
                        b_reg     <= b_i;
                        carry_reg <= cin_i;
`endif
                        cnt_reg   <= '0;
                        sum_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[base_idx +: SLICE] <= slice_sum;
                    carry_reg                  <= slice_cout;
                    cnt_reg                    <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        cout_reg  <= slice_cout;
                        ovf_reg   <= slice_ctop ^ slice_cout;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // No new request can be taken here, so a response handshake
                    // and an acceptance never share a cycle.
                    if (resp_ready_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state_reg == IDLE);
    assign resp_valid_o = (state_reg == DONE);
    assign sum_o        = sum_reg;
    assign cout_o       = cout_reg;
    assign ovf_o        = ovf_reg;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Self-checking bench for cla_add_sequencer: directed cases with literal
// expectations plus randomized traffic checked against an arithmetic model.
module tb_cla_add_sequencer;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    logic        clk        = 1'b0;
    logic        rstn       = 1'b0;
    logic        req_valid  = 1'b0;
    logic        cin        = 1'b0;
    logic        sub_drv    = 1'b0;
    logic        resp_ready = 1'b0;
    logic [31:0] a          = '0;
    logic [31:0] b          = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    cla_add_sequencer #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .a_i          (a),
        .b_i          (b),
        .cin_i        (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub_i        (sub_drv),
`endif
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .sum_o        (sum),
        .cout_o       (cout),
        .ovf_o        (ovf)
    );

    // Reference: full-width integer add; overflow from operand/result signs
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic c, input logic s);
        exp_t        e;
        logic [31:0] ye;
        logic        ce;
        logic [32:0] t;
        ye     = s ? ~y : y;
        ce     = s ? 1'b1 : c;
        t      = {1'b0, x} + {1'b0, ye} + {32'd0, ce};
        e.sum  = t[31:0];
        e.cout = t[32];
        e.ovf  = (x[31] == ye[31]) && (t[31] != x[31]);
        e.acc  = 0;
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: record accepted requests into the model queue, retire on response
    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                exp_q.delete();
            end else begin
                cyc++;
                if (resp_valid && resp_ready && exp_q.size() > 0) begin
                    $display("resp sum=%h cout=%b ovf=%b", sum, cout, ovf);
                    void'(exp_q.pop_front());
                end
                if (req_valid && req_ready) begin
                    exp_t e;
                    e     = model(a, b, cin, sub_drv);
                    e.acc = cyc;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Compare process: every cycle a response is presented, check it
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (resp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        check("sum", sum, exp_q[0].sum);
                        check("cout", {31'd0, cout}, {31'd0, exp_q[0].cout});
                        check("ovf", {31'd0, ovf}, {31'd0, exp_q[0].ovf});
                        if (!prev_valid)
                            check("latency", 32'(cyc - exp_q[0].acc), 32'(NSLICE));
                    end
                    check("ready_in_done", {31'd0, req_ready}, 32'd0);
                end
                prev_valid = resp_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    // Present one request and return at the negedge after it is accepted
    task automatic issue(input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic s);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
        end else begin
            req_valid = 1'b1;
            a         = x;
            b         = y;
            cin       = c;
            sub_drv   = s;
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    // Wait for the response while scrambling operands, hold off, then accept it
    task automatic wait_resp(input int hold, input bit lit, input logic [31:0] es,
                             input logic ec, input logic eo);
        int n;
        n = 0;
        while (!resp_valid && n < 100) begin
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom);
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            check("resp_timeout", 32'd0, 32'd1);
            return;
        end
        if (lit) begin
            check("lit_sum", sum, es);
            check("lit_cout", {31'd0, cout}, {31'd0, ec});
            check("lit_ovf", {31'd0, ovf}, {31'd0, eo});
        end
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
            if (lit) check("hold_sum", sum, es);
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_sum"}, sum, 32'd0);
        check({tag, "_cout"}, {31'd0, cout}, 32'd0);
        check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rstn = 1'b1;
        @(negedge clk);

        // Carry ripples through every slice
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_resp(0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        // Positive overflow
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_resp(0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        // Carry-in honoured, with 5 cycles of backpressure and a blocked request
        issue(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        wait_resp(5, 1'b1, 32'h2345_678A, 1'b0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
        issue(32'd5, 32'd7, 1'b0, 1'b1);
        wait_resp(0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        wait_resp(0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif

        // Reset in the middle of RUN discards the operation
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_values("midrun");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (12) @(negedge clk);
        check("no_resp_after_reset", {31'd0, resp_valid}, 32'd0);
        issue(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0);
        wait_resp(0, 1'b1, 32'hDFD1_0456, 1'b0, 1'b0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 40; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            logic        s;
            x = $urandom;
            y = $urandom;
            if (i % 8 == 0) x = 32'hFFFF_FFFF;
            if (i % 8 == 1) y = 32'h8000_0000;
            s = 1'b0;
`ifdef CLA_SEQ_SUB_EN
            s = 1'($urandom);
`endif
            issue(x, y, 1'($urandom), s);
            wait_resp($urandom_range(0, 3), 1'b0, 32'd0, 1'b0, 1'b0);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
